alu_control: RTL and testbench

- Decodes the main-control ALUop field and the R-type function field into a 3-bit ALU operation select (op2, op1, op0) for the 32-bit MIPS datapath ALU.
- Sits between the main control unit / instruction register and the ALU.
- Output is registered: one clock of latency, with a valid qualifier and an illegal-encoding flag.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_control_decode.sv | 37 +++
 rtl/alu_control.sv | 56 +++++
 tb/tb_alu_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the MIPS ALU control block: ALU operation codes,
// main-control ALUop values and R-type funct encodings.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUop/funct decoder. slt/nor support is enabled by defining
// ALUCTRL_SLT_NOR_EN; otherwise those encodings decode as illegal.
module alu_control_decode
    import alu_pkg::*;
#(
    parameter logic [2:0] ILLEGAL_OP = 3'b000
) (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] op,
    output logic       illegal
);

    // Wildcard funct on memory/branch ops so unknown funct bits never leak out.
    always_comb begin
        op      = ILLEGAL_OP;
        illegal = 1'b1;
        casez ({alu_op, funct})
            {ALUOP_MEM,   6'b??????}: begin op = ALU_ADD; illegal = 1'b0; end
            {ALUOP_BR,    6'b??????}: begin op = ALU_SUB; illegal = 1'b0; end
            {ALUOP_RTYPE, F_ADD}:     begin op = ALU_ADD; illegal = 1'b0; end
            {ALUOP_RTYPE, F_SUB}:     begin op = ALU_SUB; illegal = 1'b0; end
            {ALUOP_RTYPE, F_AND}:     begin op = ALU_AND; illegal = 1'b0; end
            {ALUOP_RTYPE, F_OR}:      begin op = ALU_OR;  illegal = 1'b0; end
            {ALUOP_RTYPE, F_XOR}:     begin op = ALU_XOR; illegal = 1'b0; end
`ifdef ALUCTRL_SLT_NOR_EN
            {ALUOP_RTYPE, F_SLT}:     begin op = ALU_SLT; illegal = 1'b0; end
            {ALUOP_RTYPE, F_NOR}:     begin op = ALU_NOR; illegal = 1'b0; end
`endif
            default: begin
                op      = ILLEGAL_OP;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// Registered MIPS ALU control: decode ALUop/funct into op2..op0 with one cycle
// of latency. Optional slt/nor decode is selected with ALUCTRL_SLT_NOR_EN.
module alu_control
    import alu_pkg::*;
#(
    parameter logic [2:0] ILLEGAL_OP = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic       op2,
    output logic       op1,
    output logic       op0,
    output logic       out_valid,
    output logic       illegal
);

    logic [2:0] op_next;
    logic       illegal_next;
    logic [2:0] op_reg;
    logic       illegal_reg;
    logic       out_valid_reg;

    alu_control_decode #(
        .ILLEGAL_OP (ILLEGAL_OP)
    ) u_decode (
        .alu_op  (alu_op),
        .funct   (funct),
        .op      (op_next),
        .illegal (illegal_next)
    );

    // Result registers only load on a valid input; out_valid tracks in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= 3'b000;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                op_reg      <= op_next;
                illegal_reg <= illegal_next;
            end
        end
    end

    assign op2       = op_reg[2];
    assign op1       = op_reg[1];
    assign op0       = op_reg[0];
    assign out_valid = out_valid_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed scenarios plus randomized
// traffic against a table-driven reference model (honours ALUCTRL_SLT_NOR_EN).
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'b000000;
    logic       op2, op1, op0, out_valid, illegal;

    int checks = 0;
    int failures = 0;

    // Expected held state of the output registers.
    logic [2:0] exp_op = 3'b000;
    logic       exp_ill = 1'b0;

    alu_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .alu_op    (alu_op),
        .funct     (funct),
        .op2       (op2),
        .op1       (op1),
        .op0       (op0),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference: returns {illegal, op} from the instruction-set rules.
    function automatic logic [3:0] ref_decode(input logic [1:0] a, input logic [5:0] f);
        logic [5:0] fn [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd42, 6'd39};
        logic [2:0] oc [7] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd3, 3'd7, 3'd4};
`ifdef ALUCTRL_SLT_NOR_EN
        int n = 7;
`else
        int n = 5;
`endif
        if (a == 2'd0) return {1'b0, 3'd2};
        if (a == 2'd1) return {1'b0, 3'd6};
        if (a == 2'd2)
            for (int i = 0; i < n; i++)
                if (f == fn[i]) return {1'b0, oc[i]};
        return {1'b1, 3'd0};
    endfunction

    function automatic logic [4:0] observed();
        return {out_valid, illegal, op2, op1, op0};
    endfunction

    task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f);
        logic [3:0] r;
        in_valid = v;
        alu_op   = a;
        funct    = f;
        if (v) begin
            r       = ref_decode(a, f);
            exp_ill = r[3];
            exp_op  = r[2:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 5'b0) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", observed(), 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_op = 3'b000; exp_ill = 1'b0;
        repeat (3) tick();
        checks++;
        if (observed() !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle_hold got=%b want=%b", observed(), 5'b0);
        end
        $display("reset: out=%b", observed());
    endtask

    task automatic test_mem_branch();
        drive(1'b1, 2'b00, 6'bxxxxxx);
        tick();
        checks++;
        if (observed() !== 5'b1_0_010) begin
            failures++;
            $display("FAIL mem_add got=%b want=%b", observed(), 5'b1_0_010);
        end
        $display("mem: alu_op=00 out=%b", observed());
        drive(1'b1, 2'b01, 6'bxxxxxx);
        tick();
        checks++;
        if (observed() !== 5'b1_0_110) begin
            failures++;
            $display("FAIL branch_sub got=%b want=%b", observed(), 5'b1_0_110);
        end
        $display("branch: alu_op=01 out=%b", observed());
    endtask

    task automatic test_back_to_back();
        logic [5:0] f_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};
        logic [2:0] o_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, f_tab[i]);
            tick();
            checks++;
            if (observed() !== {2'b10, o_tab[i]}) begin
                failures++;
                $display("FAIL rtype_%0d funct=%b got=%b want=%b", i, f_tab[i], observed(), {2'b10, o_tab[i]});
            end
            $display("rtype: funct=%b out=%b", f_tab[i], observed());
        end
    endtask

    task automatic test_illegal();
        logic [1:0] a_tab [4] = '{2'b10, 2'b11, 2'b10, 2'b10};
        logic [5:0] f_tab [4] = '{6'b001000, 6'b100000, 6'b101010, 6'b100111};
        logic [4:0] want;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, a_tab[i], f_tab[i]);
`ifdef ALUCTRL_SLT_NOR_EN
            want = (i == 2) ? 5'b1_0_111 : (i == 3) ? 5'b1_0_100 : 5'b1_1_000;
`else
            want = 5'b1_1_000;
`endif
            tick();
            checks++;
            if (observed() !== want) begin
                failures++;
                $display("FAIL illegal_%0d alu_op=%b funct=%b got=%b want=%b", i, a_tab[i], f_tab[i], observed(), want);
            end
            $display("illegal: alu_op=%b funct=%b out=%b", a_tab[i], f_tab[i], observed());
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'b10, 6'b100110);
        tick();
        checks++;
        if (observed() !== 5'b1_0_011) begin
            failures++;
            $display("FAIL hold_load got=%b want=%b", observed(), 5'b1_0_011);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 6'($urandom));
            tick();
            checks++;
            if (observed() !== 5'b0_0_011) begin
                failures++;
                $display("FAIL hold_idle_%0d got=%b want=%b", i, observed(), 5'b0_0_011);
            end
            $display("hold: alu_op=%b funct=%b out=%b", alu_op, funct, observed());
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 2'b01, 6'b000000);
        tick();
        checks++;
        if (observed() !== 5'b1_0_110) begin
            failures++;
            $display("FAIL midrst_pre got=%b want=%b", observed(), 5'b1_0_110);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 5'b0) begin
            failures++;
            $display("FAIL midrst_async got=%b want=%b", observed(), 5'b0);
        end
        tick();
        checks++;
        if (observed() !== 5'b0) begin
            failures++;
            $display("FAIL midrst_held got=%b want=%b", observed(), 5'b0);
        end
        rst_n = 1'b1;
        exp_op = 3'b000; exp_ill = 1'b0;
        drive(1'b1, 2'b10, 6'b100000);
        #1;
        checks++;
        if (observed() !== 5'b0) begin
            failures++;
            $display("FAIL midrst_release got=%b want=%b", observed(), 5'b0);
        end
        tick();
        checks++;
        if (observed() !== 5'b1_0_010) begin
            failures++;
            $display("FAIL midrst_first got=%b want=%b", observed(), 5'b1_0_010);
        end
        $display("midrst: first after release out=%b", observed());
    endtask

    task automatic test_random();
        logic [5:0] legal [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd42, 6'd39};
        logic       v;
        logic [1:0] a;
        logic [5:0] f;
        logic [4:0] want;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 2'($urandom_range(0, 3));
            f = $urandom_range(0, 1) ? legal[$urandom_range(0, 6)] : 6'($urandom);
            drive(v, a, f);
            tick();
            want = {v, exp_ill, exp_op};
            checks++;
            if (observed() !== want) begin
                failures++;
                $display("FAIL random_%0d v=%b alu_op=%b funct=%b got=%b want=%b", i, v, a, f, observed(), want);
            end
            $display("random %0d: v=%b alu_op=%b funct=%b out=%b", i, v, a, f, observed());
        end
    endtask

    initial begin
        test_reset();
        test_mem_branch();
        test_back_to_back();
        test_illegal();
        test_hold();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
